// File: rtl/c_mac_acc.sv
`default_nettype none
// ============================================================================
// Module      : c_mac_acc
// Description : Pipelined complex multiply-accumulate. Each sampled operand
//               pair (a, b) is multiplied at full precision, accumulated into
//               a group of up to ACC_LEN products, then rounded half-up and
//               saturated to an N-bit Q-format result.
// Revision    : 1.0 - initial release
// ============================================================================
module c_mac_acc #(
    parameter int N       = 16,
    parameter int Q       = 8,
    parameter int ACC_LEN = 4,
    parameter int MUL_LAT = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mac_clear,
    input  logic                in_valid,
    input  logic                in_last,
    input  logic signed [N-1:0] in_ar,
    input  logic signed [N-1:0] in_ai,
    input  logic signed [N-1:0] in_br,
    input  logic signed [N-1:0] in_bi,
    output logic signed [N-1:0] out_r,
    output logic signed [N-1:0] out_i,
    output logic                out_valid,
    output logic                out_sat
);

    localparam int c_CNT_W = $clog2(ACC_LEN);
    localparam int c_P_W   = 2 * N + 1;
    localparam int c_ACC_W = c_P_W + c_CNT_W;
    // Operand register is the first multiplier stage; the rest is a delay line.
    localparam int c_DLY   = MUL_LAT - 1;
    localparam logic [c_ACC_W:0]   c_RND      = ({{c_ACC_W{1'b0}}, 1'b1} << Q) >> 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(ACC_LEN - 1);

    // Operand stage
    logic signed [N-1:0] op_ar_q, op_ai_q, op_br_q, op_bi_q;
    logic signed [N-1:0] op_ar_d, op_ai_d, op_br_d, op_bi_d;
    logic                op_v_q, op_v_d, op_l_q, op_l_d;

    // Full-precision partial products and complex product
    logic signed [2*N-1:0]   w_m_rr, w_m_ii, w_m_ri, w_m_ir;
    logic signed [c_P_W-1:0] w_pr, w_pi;

    // Product delay line with its valid/last tags
    logic signed [c_P_W-1:0] dl_pr_q [c_DLY];
    logic signed [c_P_W-1:0] dl_pr_d [c_DLY];
    logic signed [c_P_W-1:0] dl_pi_q [c_DLY];
    logic signed [c_P_W-1:0] dl_pi_d [c_DLY];
    logic [c_DLY-1:0]        dl_v_q, dl_v_d, dl_l_q, dl_l_d;

    // Accumulator and group counter
    logic signed [c_ACC_W-1:0] acc_r_q, acc_r_d, acc_i_q, acc_i_d;
    logic signed [c_ACC_W-1:0] w_pr_ext, w_pi_ext;
    logic [c_CNT_W-1:0]        cnt_q, cnt_d;
    logic                      close_q, close_d;
    logic                      w_tag_v, w_tag_l, w_close;

    // Output registers
    logic signed [N-1:0] out_r_q, out_r_d, out_i_q, out_i_d;
    logic                out_valid_q, out_valid_d, out_sat_q, out_sat_d;
    logic [N:0]          w_rs_r, w_rs_i;

    // Round half up, arithmetic shift by Q, clip to N bits; MSB flags clipping.
    function automatic logic [N:0] round_sat(input logic signed [c_ACC_W-1:0] a);
        logic signed [c_ACC_W:0] t;
        logic signed [c_ACC_W:0] s;
        logic [N:0]              res;
        t = {a[c_ACC_W-1], a} + c_RND;
        s = t >>> Q;
        if ((&s[c_ACC_W:N-1]) || (~|s[c_ACC_W:N-1])) begin
            res = {1'b0, s[N-1:0]};
        end else if (s[c_ACC_W]) begin
            res = {1'b1, 1'b1, {(N-1){1'b0}}};
        end else begin
            res = {1'b1, 1'b0, {(N-1){1'b1}}};
        end
        return res;
    endfunction

    // Capture operands; a clear drops any input sampled in the same cycle
    always_comb begin
        op_ar_d = in_ar;
        op_ai_d = in_ai;
        op_br_d = in_br;
        op_bi_d = in_bi;
        op_v_d  = in_valid & ~mac_clear;
        op_l_d  = in_valid & in_last & ~mac_clear;
    end

    assign w_m_rr = op_ar_q * op_br_q;
    assign w_m_ii = op_ai_q * op_bi_q;
    assign w_m_ri = op_ar_q * op_bi_q;
    assign w_m_ir = op_ai_q * op_br_q;
    assign w_pr   = {w_m_rr[2*N-1], w_m_rr} - {w_m_ii[2*N-1], w_m_ii};
    assign w_pi   = {w_m_ri[2*N-1], w_m_ri} + {w_m_ir[2*N-1], w_m_ir};

    // Shift products and tags down the delay line; a clear kills every tag
    always_comb begin
        dl_pr_d[0] = w_pr;
        dl_pi_d[0] = w_pi;
        dl_v_d     = '0;
        dl_l_d     = '0;
        dl_v_d[0]  = op_v_q & ~mac_clear;
        dl_l_d[0]  = op_l_q;
        for (int k = 1; k < c_DLY; k++) begin
            dl_pr_d[k] = dl_pr_q[k-1];
            dl_pi_d[k] = dl_pi_q[k-1];
            dl_v_d[k]  = dl_v_q[k-1] & ~mac_clear;
            dl_l_d[k]  = dl_l_q[k-1];
        end
    end

    assign w_tag_v  = dl_v_q[c_DLY-1];
    assign w_tag_l  = dl_l_q[c_DLY-1];
    assign w_pr_ext = {{c_CNT_W{dl_pr_q[c_DLY-1][c_P_W-1]}}, dl_pr_q[c_DLY-1]};
    assign w_pi_ext = {{c_CNT_W{dl_pi_q[c_DLY-1][c_P_W-1]}}, dl_pi_q[c_DLY-1]};

    // Load on the first product of a group, add otherwise; close on count or last
    always_comb begin
        acc_r_d = acc_r_q;
        acc_i_d = acc_i_q;
        cnt_d   = cnt_q;
        close_d = 1'b0;
        w_close = w_tag_l || (cnt_q == c_CNT_LAST);
        if (mac_clear) begin
            acc_r_d = '0;
            acc_i_d = '0;
            cnt_d   = '0;
        end else if (w_tag_v) begin
            if (cnt_q == '0) begin
                acc_r_d = w_pr_ext;
                acc_i_d = w_pi_ext;
            end else begin
                acc_r_d = acc_r_q + w_pr_ext;
                acc_i_d = acc_i_q + w_pi_ext;
            end
            close_d = w_close;
            cnt_d   = w_close ? '0 : cnt_q + 1'b1;
        end
    end

    assign w_rs_r = round_sat(acc_r_q);
    assign w_rs_i = round_sat(acc_i_q);

    // Publish a closed group one cycle after its final accumulation
    always_comb begin
        out_r_d     = out_r_q;
        out_i_d     = out_i_q;
        out_sat_d   = out_sat_q;
        out_valid_d = 1'b0;
        if (close_q && !mac_clear) begin
            out_valid_d = 1'b1;
            out_r_d     = w_rs_r[N-1:0];
            out_i_d     = w_rs_i[N-1:0];
            out_sat_d   = w_rs_r[N] | w_rs_i[N];
        end
    end

    // Multiplier pipeline state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_ar_q <= '0;
            op_ai_q <= '0;
            op_br_q <= '0;
            op_bi_q <= '0;
            op_v_q  <= 1'b0;
            op_l_q  <= 1'b0;
            dl_v_q  <= '0;
            dl_l_q  <= '0;
            for (int k = 0; k < c_DLY; k++) begin
                dl_pr_q[k] <= '0;
                dl_pi_q[k] <= '0;
            end
        end else begin
            op_ar_q <= op_ar_d;
            op_ai_q <= op_ai_d;
            op_br_q <= op_br_d;
            op_bi_q <= op_bi_d;
            op_v_q  <= op_v_d;
            op_l_q  <= op_l_d;
            dl_v_q  <= dl_v_d;
            dl_l_q  <= dl_l_d;
            for (int k = 0; k < c_DLY; k++) begin
                dl_pr_q[k] <= dl_pr_d[k];
                dl_pi_q[k] <= dl_pi_d[k];
            end
        end
    end

    // Accumulator, counter and output state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r_q     <= '0;
            acc_i_q     <= '0;
            cnt_q       <= '0;
            close_q     <= 1'b0;
            out_r_q     <= '0;
            out_i_q     <= '0;
            out_valid_q <= 1'b0;
            out_sat_q   <= 1'b0;
        end else begin
            acc_r_q     <= acc_r_d;
            acc_i_q     <= acc_i_d;
            cnt_q       <= cnt_d;
            close_q     <= close_d;
            out_r_q     <= out_r_d;
            out_i_q     <= out_i_d;
            out_valid_q <= out_valid_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_r     = out_r_q;
    assign out_i     = out_i_q;
    assign out_valid = out_valid_q;
    assign out_sat   = out_sat_q;

endmodule
`default_nettype wire

// File: tb/tb_c_mac_acc.sv
`default_nettype none
// ============================================================================
// Module      : tb_c_mac_acc
// Description : Scoreboard bench for c_mac_acc; an integer-arithmetic group
//               model queues expected results, a monitor checks each pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_c_mac_acc;

    localparam int N       = 16;
    localparam int Q       = 8;
    localparam int ACC_LEN = 4;
    localparam int MUL_LAT = 6;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic                mac_clear = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_last = 1'b0;
    logic signed [N-1:0] in_ar = '0, in_ai = '0, in_br = '0, in_bi = '0;
    logic signed [N-1:0] out_r, out_i;
    logic                out_valid, out_sat;

    c_mac_acc #(.N(N), .Q(Q), .ACC_LEN(ACC_LEN), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .mac_clear(mac_clear),
        .in_valid(in_valid), .in_last(in_last),
        .in_ar(in_ar), .in_ai(in_ai), .in_br(in_br), .in_bi(in_bi),
        .out_r(out_r), .out_i(out_i), .out_valid(out_valid), .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    // cyc equals the number of rising edges seen so far
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        longint r;
        longint i;
        bit     sat;
        int     exp_cyc;
    } exp_t;

    exp_t   sb[$];
    int     n_chk = 0, n_fail = 0;
    longint grp_r = 0, grp_i = 0;
    int     grp_n = 0;
    int     n_valid = 0, last_vcyc = -100, prev_vcyc = -100;
    longint last_r = 0, last_i = 0;
    bit     last_sat = 1'b0;

    function automatic longint rnd(input longint acc);
        return (acc + (longint'(1) <<< (Q - 1))) >>> Q;
    endfunction

    function automatic longint clip(input longint v);
        longint hi = (longint'(1) <<< (N - 1)) - 1;
        longint lo = -(longint'(1) <<< (N - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Issue one operand pair; the model closes groups by count or last flag
    task automatic send(input longint ar, input longint ai, input longint br,
                        input longint bi, input bit last);
        exp_t e;
        longint pr, pi, rr, ri;
        @(negedge clk);
        in_valid = 1'b1;
        in_last  = last;
        in_ar    = ar[N-1:0];
        in_ai    = ai[N-1:0];
        in_br    = br[N-1:0];
        in_bi    = bi[N-1:0];
        pr = ar * br - ai * bi;
        pi = ar * bi + ai * br;
        if (grp_n == 0) begin
            grp_r = pr;
            grp_i = pi;
        end else begin
            grp_r += pr;
            grp_i += pi;
        end
        grp_n++;
        if (last || grp_n == ACC_LEN) begin
            rr        = rnd(grp_r);
            ri        = rnd(grp_i);
            e.r       = clip(rr);
            e.i       = clip(ri);
            e.sat     = (e.r != rr) || (e.i != ri);
            e.exp_cyc = cyc + 1 + MUL_LAT + 1;
            sb.push_back(e);
            grp_n = 0;
        end
    endtask

    // Idle cycles with a random in_last that must be ignored
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'($urandom_range(0, 1));
        end
    endtask

    // Clear for one cycle; optionally with a colliding input that must be dropped
    task automatic do_clear(input bit with_in);
        @(negedge clk);
        mac_clear = 1'b1;
        in_valid  = with_in;
        in_last   = 1'b0;
        in_ar     = 16'sd20000;
        in_br     = 16'sd20000;
        grp_n     = 0;
        for (int k = sb.size() - 1; k >= 0; k--)
            if (sb[k].exp_cyc >= cyc + 1) sb.delete(k);
        @(negedge clk);
        mac_clear = 1'b0;
        in_valid  = 1'b0;
    endtask

    // Monitor: every pulse must match the head of the scoreboard, on time
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].exp_cyc < cyc && !out_valid) begin
            e = sb.pop_front();
            n_chk++;
            n_fail++;
            $display("FAIL missing_out_valid: expected at cycle %0d, now %0d", e.exp_cyc, cyc);
        end
        if (out_valid) begin
            n_valid++;
            prev_vcyc = last_vcyc;
            last_vcyc = cyc;
            last_r    = out_r;
            last_i    = out_i;
            last_sat  = out_sat;
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_out_valid: cycle %0d r=%0d i=%0d, required no output",
                         cyc, out_r, out_i);
            end else begin
                e = sb.pop_front();
                if (out_r != e.r || out_i != e.i || out_sat != e.sat || cyc != e.exp_cyc) begin
                    n_fail++;
                    $display("FAIL result: got r=%0d i=%0d sat=%0d cyc=%0d, required r=%0d i=%0d sat=%0d cyc=%0d",
                             out_r, out_i, out_sat, cyc, e.r, e.i, e.sat, e.exp_cyc);
                end
            end
        end
    end

    initial begin
        int v0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_out_r", out_r, 0);
        chk("reset_out_i", out_i, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_sat", out_sat, 0);
        rst_n = 1'b1;
        idle(2);

        // Basic group
        for (int k = 0; k < 4; k++) send(256, 256, 256, -256, 1'b0);
        idle(10);
        chk("basic_r", last_r, 2048);
        chk("basic_i", last_i, 0);
        chk("basic_sat", last_sat, 0);

        // Rounding with early close
        send(128, 0, 1, 0, 1'b1);
        idle(10);
        chk("round_half_up", last_r, 1);
        send(-128, 0, 1, 0, 1'b1);
        idle(10);
        chk("round_neg_half", last_r, 0);

        // Saturation both ways
        for (int k = 0; k < 4; k++) send(32512, 0, 32512, 0, 1'b0);
        idle(10);
        chk("sat_pos_r", last_r, 32767);
        chk("sat_pos_i", last_i, 0);
        chk("sat_pos_flag", last_sat, 1);
        for (int k = 0; k < 4; k++) send(-32512, 0, 32512, 0, 1'b0);
        idle(10);
        chk("sat_neg_r", last_r, -32768);
        chk("sat_neg_flag", last_sat, 1);

        // Gaps between inputs
        v0 = n_valid;
        for (int k = 0; k < 8; k++) begin
            send(256, 0, 256, 0, 1'b0);
            idle($urandom_range(0, 3));
        end
        idle(10);
        chk("gap_count", n_valid - v0, 2);
        chk("gap_r", last_r, 1024);

        // Back-to-back groups
        for (int k = 0; k < 8; k++) send(256, 0, 256, 0, 1'b0);
        idle(10);
        chk("stream_spacing", last_vcyc - prev_vcyc, 4);

        // Clear keeps the published result
        do_clear(1'b0);
        idle(2);
        chk("clear_hold_r", out_r, 1024);

        // Clear mid-group with a colliding input, then a fresh group
        v0 = n_valid;
        send(256, 0, 256, 0, 1'b0);
        send(256, 0, 256, 0, 1'b0);
        do_clear(1'b1);
        for (int k = 0; k < 4; k++) send(256, 0, 256, 0, 1'b0);
        idle(12);
        chk("clear_count", n_valid - v0, 1);
        chk("clear_r", last_r, 1024);

        // Randomized traffic
        for (int it = 0; it < 400; it++) begin
            int sel = $urandom_range(0, 19);
            if (sel == 0) do_clear(1'($urandom_range(0, 1)));
            else if (sel < 5) idle($urandom_range(1, 3));
            else send(longint'($urandom_range(0, 65535)) - 32768,
                      longint'($urandom_range(0, 65535)) - 32768,
                      longint'($urandom_range(0, 65535)) - 32768,
                      longint'($urandom_range(0, 65535)) - 32768,
                      $urandom_range(0, 7) == 0);
        end
        idle(12);

        // Asynchronous reset mid-group
        for (int k = 0; k < 4; k++) send(256, 0, 256, 0, 1'b0);
        idle(10);
        send(256, 0, 256, 0, 1'b0);
        send(256, 0, 256, 0, 1'b0);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        grp_n = 0;
        #1;
        chk("async_rst_out_r", out_r, 0);
        chk("async_rst_out_i", out_i, 0);
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_out_sat", out_sat, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        v0 = n_valid;
        idle(15);
        chk("no_stale_valid", n_valid - v0, 0);
        for (int k = 0; k < 4; k++) send(256, 0, 256, 0, 1'b0);
        idle(12);
        chk("post_reset_count", n_valid - v0, 1);
        chk("post_reset_r", last_r, 1024);

        for (int k = 0; k < 40 && sb.size() != 0; k++) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/c_mac_acc.md
C_MAC_ACC -- requirements
Module: c_mac_acc

Interface
REQ-001 SHALL provide parameter N, default 16, total bit width of input and output samples (signed, two's complement).
REQ-002 SHALL provide parameter Q, default 8, fractional bits of input and output samples (Q < N).
REQ-003 SHALL provide parameter ACC_LEN, default 4, products per result group (2..256).
REQ-004 SHALL provide parameter MUL_LAT, default 6, complex-multiplier pipeline depth in cycles (>= 2).
REQ-005 SHALL provide port clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL provide port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL provide port mac_clear  input  1  synchronous flush of accumulator, counter and in-flight data.
REQ-008 SHALL provide port in_valid  input  1  in_ar/in_ai/in_br/in_bi valid this cycle.
REQ-009 SHALL provide port in_last  input  1  qualified by in_valid; this sample closes the group early.
REQ-010 SHALL provide ports in_ar, in_ai, in_br, in_bi  input  N each  signed complex operands a and b.
REQ-011 SHALL provide ports out_r, out_i  output  N each  registered signed group result.
REQ-012 SHALL provide port out_valid  output  1  single-cycle pulse; out_r/out_i/out_sat valid.
REQ-013 SHALL provide port out_sat  output  1  either component saturated in this result.

Function
REQ-014 SHALL compute full-precision product pr = ar*br - ai*bi and pi = ar*bi + ai*br, width 2N+1, 2Q fractional bits, no truncation inside the multiplier.
REQ-015 SHALL delay a valid/last tag alongside the multiplier so each product is tagged exactly MUL_LAT cycles after its operands are sampled.
REQ-016 SHALL hold accumulators of width ACC_W = 2N+1+ceil(log2(ACC_LEN)); no internal overflow is possible.
REQ-017 SHALL, on a tagged product, load the accumulator with the product if it is the first of a group, otherwise add it; back-to-back groups have no bubble.
REQ-018 SHALL count tagged products 0..ACC_LEN-1; group closes on count ACC_LEN-1 or tagged in_last, whichever first; counter returns to 0 after close.
REQ-019 SHALL form each output as (acc_final + 2^(Q-1)) arithmetically shifted right by Q (round half up), then saturate to [-2^(N-1), 2^(N-1)-1].
REQ-020 SHALL assert out_valid for exactly one cycle, MUL_LAT+1 cycles after the closing input is sampled; out_r/out_i/out_sat hold until the next out_valid.
REQ-021 SHALL set out_sat = 1 when either component clipped, else 0, updated with each out_valid.
REQ-022 SHALL tolerate arbitrary gaps in in_valid; idle cycles leave accumulator and counter unchanged.
REQ-023 SHALL, on mac_clear, zero counter, accumulators and all valid tags next edge; in-flight products are discarded and never produce out_valid.
REQ-024 SHALL give mac_clear priority over a simultaneous in_valid; that input is dropped.
REQ-025 SHALL not alter out_r/out_i/out_sat on mac_clear.
REQ-026 SHALL ignore in_last when in_valid = 0.

Reset
REQ-027 SHALL, while rst_n = 0, force out_r = 0, out_i = 0, out_valid = 0, out_sat = 0, counter = 0, accumulators = 0, all valid tags = 0, independent of clk.
REQ-028 SHALL produce no out_valid from data sampled before or during reset; first group starts with the first in_valid after rst_n rises.

Verification (N=16, Q=8, ACC_LEN=4, MUL_LAT=6)
REQ-029 SHALL verify basic group: 4 consecutive a=(256+j256), b=(256-j256) -> out_r=2048, out_i=0, out_sat=0, out_valid 7 cycles after 4th input.
REQ-030 SHALL verify rounding and early close: a=128, b=1 with in_last -> out_r=1; a=-128, b=1 with in_last -> out_r=0.
REQ-031 SHALL verify saturation: 4x a=32512, b=32512 (real) -> out_r=32767, out_i=0, out_sat=1; 4x a=-32512, b=32512 -> out_r=-32768, out_sat=1.
REQ-032 SHALL verify gaps and back-to-back: 8 inputs of a=b=256 with random idle cycles -> two results out_r=1024; no-gap streaming -> out_valid pulses exactly 4 cycles apart.
REQ-033 SHALL verify mac_clear after 2 inputs of a group, then 4 fresh inputs a=b=256 -> exactly one out_valid, out_r=1024.
REQ-034 SHALL verify rst_n low mid-group -> all outputs 0 immediately; no stale out_valid after release.
